// File: rtl/io_in.sv
// io_in: synchronizes and debounces slide switches and push-buttons, with sticky clear-on-read press events
// Ports: clock, reset (asynchronous, active-high); sw raw switches; key_n raw active-low buttons;
//    addr register select (0 switches, 1 events, 2 button levels, 3 zero); rd read strobe;
//    dout registered read data; irq interrupt while any event flag is set, present only with IO_IN_IRQ_EN.
module io_in #(
   parameter int SW_W      = 10,
   parameter int KEY_W     = 3,
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [SW_W-1:0]  sw,
   input  logic [KEY_W-1:0] key_n,
   input  logic [1:0]       addr,
   input  logic             rd,
   output logic [31:0]      dout
`ifdef IO_IN_IRQ_EN
   ,
   output logic             irq
`endif
);
   localparam int N = SW_W + KEY_W;
   localparam logic [N-1:0] RST = {{KEY_W{1'b1}}, {SW_W{1'b0}}};
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
   logic [N-1:0] s1, s2, q, hit, qn;
   logic [CNT_W-1:0] cnt [N];
   logic [KEY_W-1:0] ev, ev_next, pressed, rise;
   logic [31:0] word;
   always_comb begin
      hit = '0;
      for (int i = 0; i < N; i++) hit[i] = (s2[i] != q[i]) && (cnt[i] == LAST);
      qn = q ^ hit;
      pressed = ~q[N-1:SW_W];
      rise = q[N-1:SW_W] & ~qn[N-1:SW_W];
      // a press qualifying on the clearing read still lands, so no event is lost
      ev_next = ((rd && addr == 2'd1) ? '0 : ev) | rise;
      word = addr == 2'd0 ? 32'(q[SW_W-1:0]) :
             addr == 2'd1 ? 32'(ev) :
             addr == 2'd2 ? 32'(pressed) : 32'h0;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= RST;
         s2 <= RST;
         q <= RST;
         ev <= '0;
         dout <= '0;
         for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         s1 <= {key_n, sw};
         s2 <= s1;
         q <= qn;
         ev <= ev_next;
         dout <= word;
         for (int i = 0; i < N; i++) cnt[i] <= (s2[i] == q[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
      end
   end
`ifdef IO_IN_IRQ_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) irq <= 1'b0;
      else irq <= |ev_next;
   end
`endif
endmodule

// File: tb/tb_io_in.sv
// tb_io_in: scoreboard bench for io_in with DB_CYCLES=4
module tb_io_in;
   logic clock = 0, reset = 1, rd = 0, issue = 0, pend = 0;
   logic [9:0] sw = 10'h3FF;
   logic [2:0] key_n = 3'b000;
   logic [1:0] addr = 2'd1;
   logic [31:0] dout;
   int vecs = 0, errs = 0;
   typedef struct {logic [31:0] exp; string nm;} exp_t;
   exp_t sb[$];
`ifdef IO_IN_IRQ_EN
   logic irq;
   io_in #(.SW_W(10), .KEY_W(3), .DB_CYCLES(4), .CNT_W(3)) dut (
      .clock(clock), .reset(reset), .sw(sw), .key_n(key_n),
      .addr(addr), .rd(rd), .dout(dout), .irq(irq));
`else
   io_in #(.SW_W(10), .KEY_W(3), .DB_CYCLES(4), .CNT_W(3)) dut (
      .clock(clock), .reset(reset), .sw(sw), .key_n(key_n),
      .addr(addr), .rd(rd), .dout(dout));
`endif
   always #5 clock = ~clock;
   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endfunction
   always @(posedge clock) pend <= issue;
   always @(negedge clock) begin
      exp_t e;
      if (pend) begin
         if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check(e.nm, dout, e.exp);
         end
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask
   task automatic rd_chk(input logic [1:0] a, input logic r, input logic [31:0] exp, input string nm);
      addr = a;
      rd = r;
      issue = 1;
      sb.push_back('{exp, nm});
      @(negedge clock);
      rd = 0;
      issue = 0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      tick(3);
      check("reset_dout", dout, 32'h0);
`ifdef IO_IN_IRQ_EN
      check("reset_irq", {31'h0, irq}, 32'h0);
`endif
      reset = 0;
      tick(5);
      rd_chk(2'd0, 0, 32'h0, "post_reset_early");
      rd_chk(2'd0, 0, 32'h3FF, "post_reset_sw");
      rd_chk(2'd2, 0, 32'h7, "post_reset_pressed");
      rd_chk(2'd1, 1, 32'h7, "post_reset_ev_clear");
      rd_chk(2'd1, 0, 32'h0, "ev_after_clear");
      rd_chk(2'd3, 1, 32'h0, "addr3_zero");
      sw = 10'h000;
      key_n = 3'b111;
      tick(10);
      rd_chk(2'd0, 0, 32'h0, "sw_released");
      rd_chk(2'd2, 0, 32'h0, "keys_released");
      rd_chk(2'd1, 0, 32'h0, "release_no_event");
      sw[0] = 1;
      tick(3);
      sw[0] = 0;
      tick(8);
      rd_chk(2'd0, 0, 32'h0, "glitch_rejected");
      sw[0] = 1;
      tick(6);
      rd_chk(2'd0, 0, 32'h1, "sw0_held");
      sw = 10'h2A5;
      tick(6);
      rd_chk(2'd0, 0, 32'h2A5, "sw_pattern");
      key_n = 3'b101;
      tick(6);
      rd_chk(2'd2, 0, 32'h2, "key1_pressed");
      rd_chk(2'd1, 0, 32'h2, "key1_event");
      rd_chk(2'd2, 1, 32'h2, "rd_addr2_no_side_effect");
      rd_chk(2'd1, 1, 32'h2, "key1_clear_read");
      rd_chk(2'd1, 0, 32'h0, "key1_ev_cleared");
      rd_chk(2'd2, 0, 32'h2, "key1_still_held");
      key_n = 3'b111;
      tick(8);
      key_n = 3'b011;
      tick(8);
      key_n = 3'b111;
      tick(8);
      rd_chk(2'd1, 0, 32'h4, "key2_event");
      key_n = 3'b110;
      tick(5);
      rd_chk(2'd1, 1, 32'h4, "set_clear_same_edge");
      rd_chk(2'd1, 0, 32'h1, "set_wins_over_clear");
      rd_chk(2'd1, 1, 32'h1, "key0_clear");
      key_n = 3'b111;
      tick(8);
      rd_chk(2'd1, 0, 32'h0, "bounce_pre");
      for (int i = 0; i < 10; i++) begin
         key_n[2] = ~key_n[2];
         tick(2);
      end
      rd_chk(2'd1, 0, 32'h0, "bounce_no_event");
      key_n[2] = 0;
      tick(6);
      rd_chk(2'd1, 1, 32'h4, "bounce_hold_event");
      rd_chk(2'd1, 0, 32'h0, "bounce_single_event");
      key_n = 3'b111;
      tick(8);
`ifdef IO_IN_IRQ_EN
      check("irq_idle", {31'h0, irq}, 32'h0);
      key_n = 3'b110;
      tick(5);
      check("irq_before_event", {31'h0, irq}, 32'h0);
      tick(1);
      check("irq_after_event", {31'h0, irq}, 32'h1);
      tick(2);
      check("irq_held", {31'h0, irq}, 32'h1);
      rd_chk(2'd1, 1, 32'h1, "irq_clear_read");
      check("irq_dropped", {31'h0, irq}, 32'h0);
      key_n = 3'b111;
      tick(8);
`endif
      tick(2);
      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
